rrat: RTL and testbench

Retirement register alias table. Receives in-order commit packets from the ROB and updates the committed architectural-to-physical map. It returns each overwritten physical register to the architectural free list and broadcasts the freed PRNs to the speculative RAT. On a commit-time squash, it sends the full committed map and free-list image, and the RAT overwrites its own table and free list from that image.

---
 rtl/rrat_pkg.sv | 37 +++
 rtl/rrat_free_list.sv | 50 +++++
 rtl/rrat.sv | 95 +++++++++
 tb/tb_rrat.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/rrat_pkg.sv
// Shared types and sizing for the retirement alias table and the RAT that consumes its broadcast.
package rrat_pkg;

  localparam int unsigned ARCH_REG_NUM = 32;
  localparam int unsigned PHYS_REG_NUM = 64;
  localparam int unsigned CT_WIDTH     = 2;
  localparam int unsigned FL_DEPTH     = PHYS_REG_NUM - ARCH_REG_NUM;

  localparam int unsigned PRN_W  = $clog2(PHYS_REG_NUM);
  localparam int unsigned AR_W   = $clog2(ARCH_REG_NUM);
  localparam int unsigned HEAD_W = $clog2(FL_DEPTH);

  typedef logic [PRN_W-1:0] PRN;
  typedef logic [AR_W-1:0]  ARCH_REG;

  typedef struct packed {
    logic    valid;
    logic    has_dest;
    ARCH_REG arch_reg;
    PRN      prn;
  } ROB_CT_PACKET;

  typedef struct packed {
    logic                    squash;
    logic [CT_WIDTH-1:0]     free_valid;
    PRN   [CT_WIDTH-1:0]     free_prn;
    PRN   [ARCH_REG_NUM-1:0] rrat_table;
    PRN   [FL_DEPTH-1:0]     free_list;
    logic [HEAD_W-1:0]       head;
  } RRAT_CT_OUTPUT;

  // Only commits that actually rename a non-zero architectural register touch state.
  function automatic logic is_effective(input ROB_CT_PACKET p);
    return p.valid && p.has_dest && (p.arch_reg != '0);
  endfunction

endpackage

// File: rtl/rrat_free_list.sv
// Architectural free list: circular array that is always full; each write replaces the entry at head and advances it.
module rrat_free_list
  import rrat_pkg::*;
(
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CT_WIDTH-1:0]       wr_en,
  input  PRN   [CT_WIDTH-1:0]       wr_data,
  output PRN   [CT_WIDTH-1:0]       expected,
  output PRN   [FL_DEPTH-1:0]       fl,
  output logic [HEAD_W-1:0]         head
);

  PRN   [FL_DEPTH-1:0] fl_q;
  PRN   [FL_DEPTH-1:0] fl_d;
  logic [HEAD_W-1:0]   head_q;
  logic [HEAD_W-1:0]   head_d;
  logic [HEAD_W-1:0]   pos;

  // Each enabled slot claims the next position; expected values are read before any same-cycle write.
  always_comb begin
    fl_d     = fl_q;
    pos      = head_q;
    expected = '0;
    for (int unsigned i = 0; i < CT_WIDTH; i++) begin
      expected[i] = fl_q[pos];
      if (wr_en[i]) begin
        fl_d[pos] = wr_data[i];
        pos       = pos + 1'b1;
      end
    end
    head_d = pos;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned j = 0; j < FL_DEPTH; j++) begin
        fl_q[j] <= PRN'(ARCH_REG_NUM + j);
      end
      head_q <= '0;
    end else begin
      fl_q   <= fl_d;
      head_q <= head_d;
    end
  end

  assign fl   = fl_q;
  assign head = head_q;

endmodule

// File: rtl/rrat.sv
// Retirement RAT: applies in-order commits to the committed map, recycles old PRNs and broadcasts the image.
module rrat
  import rrat_pkg::*;
(
  input  logic                          clock,
  input  logic                          reset,
  input  ROB_CT_PACKET [CT_WIDTH-1:0]   rob_ct_packet,
  input  logic                          squash,
  output RRAT_CT_OUTPUT                 rrat_ct_output,
  output logic                          alloc_mismatch
);

  PRN   [ARCH_REG_NUM-1:0] table_q;
  PRN   [ARCH_REG_NUM-1:0] table_d;
  logic [CT_WIDTH-1:0]     eff;
  PRN   [CT_WIDTH-1:0]     old_prn;
  PRN   [CT_WIDTH-1:0]     expected;
  PRN   [FL_DEPTH-1:0]     fl;
  logic [HEAD_W-1:0]       head;
  logic                    mismatch_d;

  logic                    squash_q;
  logic [CT_WIDTH-1:0]     free_valid_q;
  PRN   [CT_WIDTH-1:0]     free_prn_q;
  logic                    mismatch_q;

  always_comb begin
    eff = '0;
    for (int unsigned i = 0; i < CT_WIDTH; i++) begin
      eff[i] = is_effective(rob_ct_packet[i]);
    end
  end

  // Slots chain through the running table so a younger slot sees an older slot's new mapping.
  always_comb begin
    table_d = table_q;
    old_prn = '0;
    for (int unsigned i = 0; i < CT_WIDTH; i++) begin
      if (eff[i]) begin
        old_prn[i]                          = table_d[rob_ct_packet[i].arch_reg];
        table_d[rob_ct_packet[i].arch_reg]  = rob_ct_packet[i].prn;
      end
    end
  end

  always_comb begin
    mismatch_d = 1'b0;
    for (int unsigned i = 0; i < CT_WIDTH; i++) begin
      if (eff[i] && (rob_ct_packet[i].prn != expected[i])) begin
        mismatch_d = 1'b1;
      end
    end
  end

  rrat_free_list u_free_list (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (eff),
    .wr_data  (old_prn),
    .expected (expected),
    .fl       (fl),
    .head     (head)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ARCH_REG_NUM; i++) begin
        table_q[i] <= PRN'(i);
      end
      squash_q     <= 1'b0;
      free_valid_q <= '0;
      free_prn_q   <= '0;
      mismatch_q   <= 1'b0;
    end else begin
      table_q      <= table_d;
      squash_q     <= squash;
      free_valid_q <= eff;
      free_prn_q   <= old_prn;
      mismatch_q   <= mismatch_d;
    end
  end

  always_comb begin
    rrat_ct_output            = '0;
    rrat_ct_output.squash     = squash_q;
    rrat_ct_output.free_valid = free_valid_q;
    rrat_ct_output.free_prn   = free_prn_q;
    rrat_ct_output.rrat_table = table_q;
    rrat_ct_output.free_list  = fl;
    rrat_ct_output.head       = head;
  end

  assign alloc_mismatch = mismatch_q;

endmodule

// File: tb/tb_rrat.sv
// Self-checking bench for rrat: directed test-plan scenarios plus randomized commits against an array model.
module tb_rrat;
  import rrat_pkg::*;

  logic                         clock = 1'b0;
  logic                         reset = 1'b1;
  logic                         squash = 1'b0;
  ROB_CT_PACKET [CT_WIDTH-1:0]  pkt = '0;
  RRAT_CT_OUTPUT                out;
  logic                         mm;

  int            m_tbl[ARCH_REG_NUM];
  int            m_fl[FL_DEPTH];
  int            m_head;
  RRAT_CT_OUTPUT exp_out;
  logic          exp_mm;
  int            checks = 0;
  int            errors = 0;

  rrat dut (
    .clock          (clock),
    .reset          (reset),
    .rob_ct_packet  (pkt),
    .squash         (squash),
    .rrat_ct_output (out),
    .alloc_mismatch (mm)
  );

  always #5 clock = ~clock;

  function automatic ROB_CT_PACKET mk(input bit v, input bit hd, input int a, input int p);
    ROB_CT_PACKET r;
    r.valid    = v;
    r.has_dest = hd;
    r.arch_reg = ARCH_REG'(a);
    r.prn      = PRN'(p);
    return r;
  endfunction

  function automatic RRAT_CT_OUTPUT image();
    RRAT_CT_OUTPUT o;
    o = '0;
    for (int a = 0; a < ARCH_REG_NUM; a++) o.rrat_table[a] = PRN'(m_tbl[a]);
    for (int j = 0; j < FL_DEPTH; j++) o.free_list[j] = PRN'(m_fl[j]);
    o.head = HEAD_W'(m_head);
    return o;
  endfunction

  // free_prn carries meaning only where free_valid is set.
  function automatic RRAT_CT_OUTPUT masked(input RRAT_CT_OUTPUT o);
    RRAT_CT_OUTPUT r;
    r = o;
    for (int s = 0; s < CT_WIDTH; s++) if (!r.free_valid[s]) r.free_prn[s] = '0;
    return r;
  endfunction

  function automatic void model_reset();
    for (int a = 0; a < ARCH_REG_NUM; a++) m_tbl[a] = a;
    for (int j = 0; j < FL_DEPTH; j++) m_fl[j] = ARCH_REG_NUM + j;
    m_head  = 0;
    exp_out = image();
    exp_mm  = 1'b0;
  endfunction

  // Drive one cycle of inputs, advance the model by the commit rules, and sample after the edge.
  task automatic step(input ROB_CT_PACKET [CT_WIDTH-1:0] p, input bit sq);
    logic [CT_WIDTH-1:0] fv;
    PRN   [CT_WIDTH-1:0] fp;
    logic                m;
    int                  old;
    pkt    = p;
    squash = sq;
    fv = '0; fp = '0; m = 1'b0;
    for (int s = 0; s < CT_WIDTH; s++) begin
      if (p[s].valid && p[s].has_dest && p[s].arch_reg != 0) begin
        if (int'(p[s].prn) != m_fl[m_head]) m = 1'b1;
        old                    = m_tbl[p[s].arch_reg];
        m_tbl[p[s].arch_reg]   = p[s].prn;
        m_fl[m_head]           = old;
        m_head                 = (m_head + 1) % FL_DEPTH;
        fv[s]                  = 1'b1;
        fp[s]                  = PRN'(old);
      end
    end
    exp_out            = image();
    exp_out.squash     = sq;
    exp_out.free_valid = fv;
    exp_out.free_prn   = fp;
    exp_mm             = m;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    #1 reset = 1'b0;
    model_reset();
    #2;
    checks++; if (masked(out) !== exp_out) begin errors++; $display("FAIL reset_img got=%h exp=%h", masked(out), exp_out); end
    checks++; if (out.rrat_table[5] !== PRN'(5)) begin errors++; $display("FAIL reset_tbl5 got=%0d exp=5", out.rrat_table[5]); end
    checks++; if (out.free_list[0] !== PRN'(32)) begin errors++; $display("FAIL reset_fl0 got=%0d exp=32", out.free_list[0]); end
    checks++; if (out.head !== 5'd0 || out.squash !== 1'b0) begin errors++; $display("FAIL reset_head_sq got=%0d/%0b exp=0/0", out.head, out.squash); end
    checks++; if (mm !== 1'b0) begin errors++; $display("FAIL reset_mm got=%0b exp=0", mm); end
    @(negedge clock);
    reset = 1'b1;
    step('0, 1'b0);
    checks++; if (masked(out) !== exp_out) begin errors++; $display("FAIL idle_img got=%h exp=%h", masked(out), exp_out); end
    checks++; if (mm !== exp_mm) begin errors++; $display("FAIL idle_mm got=%0b exp=%0b", mm, exp_mm); end
  endtask

  task automatic test_single();
    ROB_CT_PACKET [CT_WIDTH-1:0] p;
    p = '0; p[0] = mk(1, 1, 3, 32);
    step(p, 1'b0);
    checks++; if (masked(out) !== exp_out) begin errors++; $display("FAIL single_img got=%h exp=%h", masked(out), exp_out); end
    checks++; if (out.free_valid !== 2'b01 || out.free_prn[0] !== PRN'(3)) begin errors++; $display("FAIL single_free got=%b/%0d exp=01/3", out.free_valid, out.free_prn[0]); end
    checks++; if (out.rrat_table[3] !== PRN'(32) || out.free_list[0] !== PRN'(3) || out.head !== 5'd1) begin
      errors++; $display("FAIL single_state got=%0d/%0d/%0d exp=32/3/1", out.rrat_table[3], out.free_list[0], out.head); end
  endtask

  task automatic test_same_arch();
    ROB_CT_PACKET [CT_WIDTH-1:0] p;
    p[0] = mk(1, 1, 7, 33); p[1] = mk(1, 1, 7, 34);
    step(p, 1'b0);
    checks++; if (masked(out) !== exp_out) begin errors++; $display("FAIL same_img got=%h exp=%h", masked(out), exp_out); end
    checks++; if (out.free_prn[1] !== PRN'(33) || out.free_prn[0] !== PRN'(7) || out.free_valid !== 2'b11) begin
      errors++; $display("FAIL same_free got=%b %0d,%0d exp=11 33,7", out.free_valid, out.free_prn[1], out.free_prn[0]); end
    checks++; if (out.rrat_table[7] !== PRN'(34) || out.free_list[1] !== PRN'(7) || out.free_list[2] !== PRN'(33) || out.head !== 5'd3) begin
      errors++; $display("FAIL same_state got=%0d/%0d/%0d/%0d exp=34/7/33/3", out.rrat_table[7], out.free_list[1], out.free_list[2], out.head); end
    checks++; if (mm !== 1'b0) begin errors++; $display("FAIL same_mm got=%0b exp=0", mm); end
  endtask

  task automatic test_noneffective();
    ROB_CT_PACKET [CT_WIDTH-1:0] p;
    p[0] = mk(1, 1, 0, 50); p[1] = mk(1, 0, 12, 51);
    step(p, 1'b0);
    checks++; if (masked(out) !== exp_out) begin errors++; $display("FAIL noneff_img got=%h exp=%h", masked(out), exp_out); end
    checks++; if (out.free_valid !== 2'b00 || out.head !== 5'd3) begin errors++; $display("FAIL noneff_fv got=%b/%0d exp=00/3", out.free_valid, out.head); end
    p = '0; p[1] = mk(1, 1, 4, 40);
    step(p, 1'b0);
    checks++; if (masked(out) !== exp_out) begin errors++; $display("FAIL mm_img got=%h exp=%h", masked(out), exp_out); end
    checks++; if (mm !== 1'b1 || out.free_valid !== 2'b10) begin errors++; $display("FAIL mm_pulse got=%0b/%b exp=1/10", mm, out.free_valid); end
    step('0, 1'b0);
    checks++; if (mm !== 1'b0) begin errors++; $display("FAIL mm_clear got=%0b exp=0", mm); end
  endtask

  task automatic test_wrap();
    ROB_CT_PACKET [CT_WIDTH-1:0] p;
    int a, old, n;
    n = 0;
    while (m_head != FL_DEPTH - 1 && n < 40) begin
      a = $urandom_range(ARCH_REG_NUM - 1, 1);
      p = '0; p[0] = mk(1, 1, a, m_fl[m_head]);
      step(p, 1'b0);
      n++;
      checks++; if (masked(out) !== exp_out) begin errors++; $display("FAIL wrap_img got=%h exp=%h", masked(out), exp_out); end
    end
    p = '0; p[0] = mk(1, 1, 20, m_fl[m_head]);
    step(p, 1'b0);
    checks++; if (out.head !== 5'd0) begin errors++; $display("FAIL wrap_head got=%0d exp=0", out.head); end
    a = 21; old = m_tbl[a];
    p = '0; p[0] = mk(1, 1, a, m_fl[m_head]);
    step(p, 1'b0);
    checks++; if (out.free_list[0] !== PRN'(old) || out.head !== 5'd1) begin
      errors++; $display("FAIL wrap_fl0 got=%0d/%0d exp=%0d/1", out.free_list[0], out.head, old); end
    checks++; if (mm !== 1'b0) begin errors++; $display("FAIL wrap_mm got=%0b exp=0", mm); end
  endtask

  task automatic test_squash();
    ROB_CT_PACKET [CT_WIDTH-1:0] p;
    p = '0; p[0] = mk(1, 1, 9, 45);
    step(p, 1'b1);
    checks++; if (masked(out) !== exp_out) begin errors++; $display("FAIL sq_img got=%h exp=%h", masked(out), exp_out); end
    checks++; if (out.squash !== 1'b1 || out.rrat_table[9] !== PRN'(45)) begin errors++; $display("FAIL sq_flag got=%0b/%0d exp=1/45", out.squash, out.rrat_table[9]); end
    for (int k = 0; k < 2; k++) begin
      step('0, 1'b1);
      checks++; if (masked(out) !== exp_out || out.squash !== 1'b1) begin errors++; $display("FAIL sq_b2b%0d got=%h exp=%h", k, masked(out), exp_out); end
    end
    step('0, 1'b0);
    checks++; if (out.squash !== 1'b0) begin errors++; $display("FAIL sq_clear got=%0b exp=0", out.squash); end
  endtask

  task automatic test_random();
    ROB_CT_PACKET [CT_WIDTH-1:0] p;
    int h;
    bit v, hd, sq;
    int a, pr;
    for (int c = 0; c < 600; c++) begin
      h = m_head;
      for (int s = 0; s < CT_WIDTH; s++) begin
        v  = ($urandom_range(3, 0) != 0);
        hd = ($urandom_range(7, 0) != 0);
        a  = (c % 50 == 0) ? 0 : $urandom_range(ARCH_REG_NUM - 1, 0);
        pr = ($urandom_range(5, 0) != 0) ? m_fl[h] : $urandom_range(PHYS_REG_NUM - 1, 0);
        p[s] = mk(v, hd, a, pr);
        if (v && hd && a != 0) h = (h + 1) % FL_DEPTH;
      end
      sq = ($urandom_range(7, 0) == 0);
      step(p, sq);
      checks++; if (masked(out) !== exp_out) begin errors++; $display("FAIL rnd_img c=%0d got=%h exp=%h", c, masked(out), exp_out); end
      checks++; if (mm !== exp_mm) begin errors++; $display("FAIL rnd_mm c=%0d got=%0b exp=%0b", c, mm, exp_mm); end
    end
  endtask

  task automatic test_async_reset();
    @(negedge clock);
    #2 reset = 1'b0;
    model_reset();
    #1;
    checks++; if (masked(out) !== exp_out) begin errors++; $display("FAIL areset_img got=%h exp=%h", masked(out), exp_out); end
    checks++; if (mm !== 1'b0 || out.squash !== 1'b0 || out.free_valid !== 2'b00) begin
      errors++; $display("FAIL areset_ctl got=%0b/%0b/%b exp=0/0/00", mm, out.squash, out.free_valid); end
    @(negedge clock);
    reset = 1'b1;
    step('0, 1'b0);
    checks++; if (masked(out) !== exp_out) begin errors++; $display("FAIL areset_idle got=%h exp=%h", masked(out), exp_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_same_arch();
    test_noneffective();
    test_wrap();
    test_squash();
    test_random();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
